// File: rtl/fusion_seq_ctrl.sv
// Job sequencer for one fusion_unit: streams operand words, sums the
// product lanes of each result and returns the scalar over valid/ready.
module fusion_seq_ctrl #(
  parameter int FU_LAT = 1,
  parameter int LEN_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [1:0]       job_cfga,
  input  logic [1:0]       job_cfgb,
  input  logic             job_sa,
  input  logic             job_sb,
  input  logic [LEN_W-1:0] job_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [7:0]       fu_a,
  output logic [7:0]       fu_b,
  output logic             fu_sa,
  output logic             fu_sb,
  output logic [1:0]       fu_cfga,
  output logic [1:0]       fu_cfgb,
  input  logic [63:0]      fu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] issued;
  logic [FU_LAT:0]  vpipe;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] lane_sum;
  logic             job_fire;
  logic             cfg_bad;
  logic             op_fire;
  logic             last_fire;
  logic             sx;
  logic             one_lane;
  logic             two_lane;

  function automatic logic [ACC_W-1:0] ext(
    input logic [15:0] v,
    input logic        s
  );
    return s ? {{(ACC_W-16){v[15]}}, v}
             : {{(ACC_W-16){1'b0}}, v};
  endfunction

  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign res_data  = acc;

  assign job_fire  = job_valid & job_ready;
  assign cfg_bad   = (job_cfga == 2'b11) | (job_cfgb == 2'b11);
  assign op_ready  = (state == RUN) && (issued < len);
  assign op_fire   = op_valid & op_ready;
  assign last_fire = op_fire && (issued == len - 1'b1);

  assign sx       = fu_sa | fu_sb;
  assign one_lane = ({fu_cfga, fu_cfgb} == 4'b1010);
  assign two_lane = ({fu_cfga, fu_cfgb} == 4'b1001)
                  | ({fu_cfga, fu_cfgb} == 4'b0110);

  // Lane layout depends only on the latched precision pair.
  always_comb begin
    lane_sum = ext(fu_out[15:0], sx);
    if (!one_lane)
      lane_sum = lane_sum + ext(fu_out[47:32], sx);
    if (!one_lane && !two_lane)
      lane_sum = lane_sum + ext(fu_out[31:16], sx)
                          + ext(fu_out[63:48], sx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      len     <= '0;
      issued  <= '0;
      vpipe   <= '0;
      acc     <= '0;
      fu_a    <= '0;
      fu_b    <= '0;
      fu_sa   <= 1'b0;
      fu_sb   <= 1'b0;
      fu_cfga <= '0;
      fu_cfgb <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      vpipe   <= {vpipe[FU_LAT-1:0], op_fire};
      if (vpipe[FU_LAT])
        acc <= acc + lane_sum;
      unique case (state)
        IDLE: begin
          if (job_fire) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              fu_cfga <= job_cfga;
              fu_cfgb <= job_cfgb;
              fu_sa   <= job_sa;
              fu_sb   <= job_sb;
              len     <= job_len;
              issued  <= '0;
              acc     <= '0;
              state   <= (job_len == '0) ? DONE : RUN;
            end
          end
        end
        RUN: begin
          if (op_fire) begin
            fu_a   <= op_a;
            fu_b   <= op_b;
            issued <= issued + 1'b1;
            if (last_fire)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          // Only the tail may be set: it is summed on this same edge.
          if (vpipe[FU_LAT-1:0] == '0)
            state <= DONE;
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// Bench for fusion_seq_ctrl with a one-cycle fusion_unit stub and a
// lane-sum reference model; directed cases followed by random jobs.
module tb_fusion_seq_ctrl;

  localparam int FU_LAT = 1;
  localparam int LEN_W  = 16;
  localparam int ACC_W  = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             job_valid;
  logic             job_ready;
  logic [1:0]       job_cfga;
  logic [1:0]       job_cfgb;
  logic             job_sa;
  logic             job_sb;
  logic [LEN_W-1:0] job_len;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [7:0]       fu_a;
  logic [7:0]       fu_b;
  logic             fu_sa;
  logic             fu_sb;
  logic [1:0]       fu_cfga;
  logic [1:0]       fu_cfgb;
  logic [63:0]      fu_out;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stub_mode = 0;
  logic [63:0] stub_const = '0;

  fusion_seq_ctrl #(
    .FU_LAT(FU_LAT), .LEN_W(LEN_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_cfga(job_cfga), .job_cfgb(job_cfgb),
    .job_sa(job_sa), .job_sb(job_sb), .job_len(job_len),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .fu_a(fu_a), .fu_b(fu_b), .fu_sa(fu_sa), .fu_sb(fu_sb),
    .fu_cfga(fu_cfga), .fu_cfgb(fu_cfgb), .fu_out(fu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] hashfn(input logic [7:0] a, b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    return {a, b, a + b, ~a, b ^ 8'hC3, a, p};
  endfunction

  function automatic logic [63:0] prodfn(
    input logic [7:0] a, b, input logic s_a, s_b);
    logic [15:0] x, y, p;
    x = s_a ? {{8{a[7]}}, a} : {8'h00, a};
    y = s_b ? {{8{b[7]}}, b} : {8'h00, b};
    p = x * y;
    return {48'h0, p};
  endfunction

  function automatic logic [63:0] fu_for(
    input logic [7:0] a, b, input logic s_a, s_b);
    if (stub_mode == 0) return stub_const;
    if (stub_mode == 1) return hashfn(a, b);
    return prodfn(a, b, s_a, s_b);
  endfunction

  // Stub fusion_unit: result appears one cycle after fu_a/fu_b change.
  always @(posedge clk or posedge rst) begin
    if (rst) fu_out <= '0;
    else     fu_out <= fu_for(fu_a, fu_b, fu_sa, fu_sb);
  end

  function automatic logic [31:0] model_sum(
    input logic [63:0] fo, input logic [1:0] ca, cb, input logic sg);
    int lanes[$];
    logic [63:0] s;
    logic [15:0] v;
    s = '0;
    if ({ca, cb} == 4'b1010) lanes = {0};
    else if ({ca, cb} == 4'b1001 || {ca, cb} == 4'b0110) lanes = {0, 2};
    else lanes = {0, 1, 2, 3};
    foreach (lanes[k]) begin
      v = fo[16*lanes[k] +: 16];
      s = s + (sg ? {{48{v[15]}}, v} : {48'h0, v});
    end
    return s[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic submit(input logic [1:0] ca, cb,
                        input logic s_a, s_b, input logic [15:0] ln);
    job_cfga = ca; job_cfgb = cb; job_sa = s_a; job_sb = s_b;
    job_len = ln; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic feed(input logic [1:0] ca, cb, input logic s_a, s_b,
                      input int len, input int pct,
                      output logic [31:0] expv, output int fire_cyc);
    int issued = 0;
    int guard = 0;
    expv = '0;
    fire_cyc = 0;
    while (issued < len && guard < 2000) begin
      op_valid = ($urandom_range(99) < pct);
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      if (op_valid && op_ready) begin
        issued++;
        expv = expv + model_sum(fu_for(op_a, op_b, s_a, s_b),
                                ca, cb, s_a | s_b);
        fire_cyc = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    op_valid = 1'b0;
    chk("feed_count", 64'(issued), 64'(len));
    chk("op_ready_after_last", 64'(op_ready), 64'(0));
  endtask

  task automatic wait_result(input logic [31:0] expv, input string tag,
                             output int vcyc);
    int n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    vcyc = cyc;
    chk({tag, "_valid"}, 64'(res_valid), 64'(1));
    chk({tag, "_data"}, 64'(res_data), 64'(expv));
  endtask

  task automatic release_res(input int hold, input string tag);
    logic [31:0] d;
    d = res_data;
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_valid"}, 64'(res_valid), 64'(1));
      chk({tag, "_hold_data"}, 64'(res_data), 64'(d));
      chk({tag, "_hold_jrdy"}, 64'(job_ready), 64'(0));
      @(negedge clk);
    end
    res_ready = 1'b1;
    chk({tag, "_jrdy_same"}, 64'(job_ready), 64'(0));
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_jrdy_next"}, 64'(job_ready), 64'(1));
    chk({tag, "_valid_low"}, 64'(res_valid), 64'(0));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_jrdy"}, 64'(job_ready), 64'(1));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_rvalid"}, 64'(res_valid), 64'(0));
    chk({tag, "_rdata"}, 64'(res_data), 64'(0));
    chk({tag, "_oprdy"}, 64'(op_ready), 64'(0));
    chk({tag, "_cfgerr"}, 64'(cfg_err), 64'(0));
    chk({tag, "_fu"}, {36'h0, fu_a, fu_b, fu_sa, fu_sb, fu_cfga, fu_cfgb},
        64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] expv;
    int fc, vc;
    logic [1:0] ca, cb;
    logic s_a, s_b;
    int ln;
    logic [7:0] pa[3];
    logic [7:0] pb[3];

    rst = 1'b1; job_valid = 0; job_cfga = 0; job_cfgb = 0;
    job_sa = 0; job_sb = 0; job_len = 0; op_valid = 0;
    op_a = 0; op_b = 0; res_ready = 0;
    repeat (3) @(negedge clk);
    chk_reset_outs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst_idle");

    // 8b x 8b unsigned, constant 100 per beat
    stub_mode = 0; stub_const = 64'h64;
    submit(2'b10, 2'b10, 0, 0, 16'd2);
    feed(2'b10, 2'b10, 0, 0, 2, 100, expv, fc);
    wait_result(32'd200, "t1", vc);
    chk("t1_lat", 64'(vc), 64'(fc + FU_LAT + 1));
    chk("t1_cfga", 64'(fu_cfga), 64'(2'b10));
    release_res(1, "t1");

    stub_const = 64'h0001_0002_0003_0004;
    submit(2'b00, 2'b00, 0, 0, 16'd2);
    feed(2'b00, 2'b00, 0, 0, 2, 100, expv, fc);
    wait_result(32'd20, "t2", vc);
    release_res(0, "t2");

    stub_const = 64'hFFFF_0003_FFFF_FFFF;
    submit(2'b10, 2'b01, 1, 1, 16'd1);
    feed(2'b10, 2'b01, 1, 1, 1, 100, expv, fc);
    wait_result(32'd2, "t3", vc);
    release_res(2, "t3");

    // Illegal precision is dropped with a single error pulse
    submit(2'b11, 2'b00, 0, 0, 16'd4);
    chk("cfg_err_pulse", 64'(cfg_err), 64'(1));
    chk("cfg_err_jrdy", 64'(job_ready), 64'(1));
    chk("cfg_err_busy", 64'(busy), 64'(0));
    chk("cfg_err_fucfg", 64'({fu_cfga, fu_cfgb}), 64'(4'b1001));
    @(negedge clk);
    chk("cfg_err_low", 64'(cfg_err), 64'(0));
    chk("cfg_err_novalid", 64'(res_valid), 64'(0));

    // Zero-length job goes straight to a zero result
    submit(2'b01, 2'b01, 0, 0, 16'd0);
    chk("len0_valid", 64'(res_valid), 64'(1));
    chk("len0_data", 64'(res_data), 64'(0));
    chk("len0_oprdy", 64'(op_ready), 64'(0));
    release_res(5, "len0");

    stub_mode = 1;
    for (int j = 0; j < 6; j++) begin
      ca = 2'($urandom_range(2));
      cb = 2'($urandom_range(2));
      s_a = 1'($urandom);
      s_b = 1'($urandom);
      ln = $urandom_range(8, 1);
      submit(ca, cb, s_a, s_b, 16'(ln));
      feed(ca, cb, s_a, s_b, ln, 50, expv, fc);
      wait_result(expv, "rand", vc);
      chk("rand_cfg", 64'({fu_cfga, fu_cfgb, fu_sa, fu_sb}),
          64'({ca, cb, s_a, s_b}));
      release_res($urandom_range(2), "rand");
    end

    // Reset while draining aborts the job
    submit(2'b01, 2'b10, 1, 0, 16'd6);
    feed(2'b01, 2'b10, 1, 0, 6, 50, expv, fc);
    chk("stress_in_drain", 64'({busy, res_valid}), 64'(2'b10));
    rst = 1'b1;
    #1;
    chk_reset_outs("stress_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("stress_after");

    // Product-computing stub, 8b signed dot product
    stub_mode = 2;
    pa[0] = -8'sd2; pb[0] = 8'sd3;
    pa[1] = 8'sd5;  pb[1] = 8'sd4;
    pa[2] = -8'sd1; pb[2] = -8'sd1;
    submit(2'b10, 2'b10, 1, 1, 16'd3);
    for (int i = 0; i < 3; i++) begin
      op_valid = 1'b1; op_a = pa[i]; op_b = pb[i];
      chk("prod_oprdy", 64'(op_ready), 64'(1));
      @(negedge clk);
    end
    op_valid = 1'b0;
    wait_result(32'(-2 * 3 + 5 * 4 + (-1) * (-1)), "prod", vc);
    release_res(1, "prod");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
